// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with overlap. State Sk means the last k bits received match
// the first k pattern bits (k maximal); q is high only in S_PAT_LEN.
// The transition table is derived at elaboration time from PATTERN/PAT_LEN.
module moore_seq_detector #(
  parameter int unsigned PAT_LEN = 4,
  parameter logic [14:0] PATTERN = 15'b000_0000_0000_1101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  output logic       q,
  output logic [3:0] current
);

  localparam logic [3:0] LastSt = 4'(PAT_LEN);

  // Bit idx of the pattern word (bit PAT_LEN-1 is received first).
  function automatic int f_pat_bit(input int idx);
    logic [14:0] t;
    t = PATTERN >> idx;
    return t[0] ? 1 : 0;
  endfunction

  // Longest prefix of the pattern that is a suffix of (first k pattern bits, then a_bit).
  // Codes above PAT_LEN are unreachable and fall back to S0.
  function automatic logic [3:0] f_next(input int k, input int a_bit);
    int best;
    int wi;
    bit ok;
    best = 0;
    if (k <= int'(PAT_LEN)) begin
      for (int j = 1; j <= int'(PAT_LEN); j++) begin
        if (j <= k + 1) begin
          ok = 1'b1;
          for (int i = 0; i < j; i++) begin
            // w[0] is the new bit; w[i] for i >= 1 walks back through the matched prefix.
            wi = (i == 0) ? a_bit : f_pat_bit(int'(PAT_LEN) - k + i - 1);
            if (wi != f_pat_bit(int'(PAT_LEN) - j + i)) ok = 1'b0;
          end
          if (ok) best = j;
        end
      end
    end
    return 4'(best);
  endfunction

  logic [3:0] w_next_tbl [16][2];
  logic [3:0] r_state_q;
  logic [3:0] w_state_d;

  for (genvar gk = 0; gk < 16; gk++) begin : g_state
    for (genvar ga = 0; ga < 2; ga++) begin : g_in
      localparam logic [3:0] NextSt = f_next(gk, ga);
      assign w_next_tbl[gk][ga] = NextSt;
    end
  end

  // Next-state lookup from the elaborated transition table.
  always_comb begin
    w_state_d = 4'd0;
    w_state_d = w_next_tbl[r_state_q][a];
  end

  // State register, asynchronously cleared to S0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_q <= 4'd0;
    end else begin
      r_state_q <= w_state_d;
    end
  end

  // Moore outputs: functions of the registered state only.
  always_comb begin
    q       = (r_state_q == LastSt);
    current = r_state_q;
  end

endmodule

// File: tb/tb_moore_seq_detector.sv
module tb_moore_seq_detector;

  logic       clk;
  logic       rst;
  logic       a_d;
  logic       a_v;
  logic       q_d;
  logic       q_v;
  logic [3:0] cur_d;
  logic [3:0] cur_v;

  int n_checks;
  int n_errors;

  moore_seq_detector u_dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a_d),
    .q       (q_d),
    .current (cur_d)
  );

  moore_seq_detector #(
    .PAT_LEN (3),
    .PATTERN (15'b000_0000_0000_0010)
  ) u_dut_var (
    .clk     (clk),
    .rst     (rst),
    .a       (a_v),
    .q       (q_v),
    .current (cur_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Default instance: present bit, clock it, then check state and detect flag.
  task automatic step_d(input string tag, input logic v, input logic [3:0] exp_cur);
    a_d = v;
    @(posedge clk);
    #1;
    chk({tag, "_cur"}, cur_d, exp_cur);
    chk({tag, "_q"}, {3'b0, q_d}, {3'b0, (exp_cur == 4'd4)});
  endtask

  task automatic step_v(input string tag, input logic v, input logic [3:0] exp_cur);
    a_v = v;
    @(posedge clk);
    #1;
    chk({tag, "_cur"}, cur_v, exp_cur);
    chk({tag, "_q"}, {3'b0, q_v}, {3'b0, (exp_cur == 4'd3)});
  endtask

  // Clock-free reset pulse between edges.
  task automatic pulse_rst();
    rst = 1'b0;
    #2;
    chk("pulse_cur", cur_d, 4'd0);
    chk("pulse_q", {3'b0, q_d}, 4'd0);
    rst = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    a_d = 1'b0;
    a_v = 1'b0;
    rst = 1'b1;
    #1;
    rst = 1'b0;

    // Held in reset with a toggling.
    for (int i = 0; i < 2; i++) begin
      a_d = ~a_d;
      a_v = ~a_v;
      @(posedge clk);
      #1;
      chk("rst_cur", cur_d, 4'd0);
      chk("rst_q", {3'b0, q_d}, 4'd0);
      chk("rst_var_cur", cur_v, 4'd0);
    end
    rst = 1'b1;
    #1;
    chk("rel_cur", cur_d, 4'd0);
    a_v = 1'b0;

    // Default stream 0,1,1,0,1,1,1,0.
    step_d("s0", 1'b0, 4'd0);
    step_d("s1", 1'b1, 4'd1);
    step_d("s2", 1'b1, 4'd2);
    step_d("s3", 1'b0, 4'd3);
    step_d("s4", 1'b1, 4'd4);
    step_d("s5", 1'b1, 4'd2);
    step_d("s6", 1'b1, 4'd2);
    step_d("s7", 1'b0, 4'd3);

    // Overlap 1101101: q pulses at the 4th and 7th bit.
    pulse_rst();
    step_d("ov0", 1'b1, 4'd1);
    step_d("ov1", 1'b1, 4'd2);
    step_d("ov2", 1'b0, 4'd3);
    step_d("ov3", 1'b1, 4'd4);
    step_d("ov4", 1'b1, 4'd2);
    step_d("ov5", 1'b0, 4'd3);
    step_d("ov6", 1'b1, 4'd4);

    // Near misses.
    pulse_rst();
    step_d("nm_a0", 1'b1, 4'd1);
    step_d("nm_a1", 1'b1, 4'd2);
    step_d("nm_a2", 1'b1, 4'd2);
    step_d("nm_a3", 1'b1, 4'd2);
    pulse_rst();
    step_d("nm_b0", 1'b1, 4'd1);
    step_d("nm_b1", 1'b0, 4'd0);
    step_d("nm_b2", 1'b1, 4'd1);
    step_d("nm_b3", 1'b0, 4'd0);

    // Async reset from S3, then resume.
    pulse_rst();
    step_d("mid0", 1'b1, 4'd1);
    step_d("mid1", 1'b1, 4'd2);
    step_d("mid2", 1'b0, 4'd3);
    pulse_rst();
    step_d("mid_res", 1'b1, 4'd1);

    // PAT_LEN=3, pattern 010.
    pulse_rst();
    chk("var_rst_cur", cur_v, 4'd0);
    step_v("v0", 1'b0, 4'd1);
    step_v("v1", 1'b1, 4'd2);
    step_v("v2", 1'b0, 4'd3);
    step_v("v3", 1'b1, 4'd2);
    step_v("v4", 1'b0, 4'd3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
- Synchronous Moore-type serial sequence detector for a single-bit input stream `a`, sampled on every rising clock edge.
- Tracks how much of a programmable bit pattern has been matched, with overlap allowed.
- Asserts `q` for exactly one cycle while in the full-match state, and exposes the state code on `current` for debug and observation.
- Sits in control/monitor logic as a standalone pattern recogniser.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 1..15, so states S0..S_PAT_LEN fit in 4 bits.
- PATTERN, 15'b000_0000_0000_1101, pattern bits in PATTERN[PAT_LEN-1:0]. Bit PAT_LEN-1 is the first bit received; bit 0 is the last. Default pattern is 1101.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- a  input  1  serial data bit, sampled on each rising clk edge.
- q  output  1  detect flag; 1 only while state == S_PAT_LEN.
- current  output  4  binary code of the present state (Sk -> k).

Behaviour:
- State register: 4 bits. State Sk means the last k received bits equal the first k pattern bits, and k is maximal.
- Reset: when rst=0, asynchronously force state to S0, so current=4'd0 and q=0. Hold while rst=0; `a` is ignored.
- After rst rises, the first rising edge evaluates the transition from S0.
- Next-state rule for state Sk and input a:
  - Form the string w = (first k pattern bits) followed by a.
  - Next state = S_j, where j is the largest value ≤ PAT_LEN such that the last j bits of w equal the first j pattern bits.
  - j=0 if no such match exists.
  - From S_PAT_LEN, w is the full pattern plus a, which gives overlapping detection.
- Default (1101) transition table, written state: a=0 -> / a=1 ->:
  - S0: S0 / S1
  - S1: S0 / S2
  - S2: S3 / S2
  - S3: S0 / S4
  - S4: S0 / S2
- Output (pure Moore): q = (state == S_PAT_LEN). q is a function of state only, never of `a` combinationally.
- current = state, registered, no extra latency.
- Latency: q rises on the rising edge that samples the final pattern bit, i.e. it is visible one cycle after that bit is presented. q stays high for exactly one clock unless the next bits complete another overlapping match.
- Back-to-back/overlap: for PATTERN 1101, the stream 1101101 gives q high twice (after bit 4 and after bit 7).
- Unused codes (PAT_LEN+1..15) are unreachable. If entered anyway, the next edge goes to S0 and q=0 while there.
- Reset mid-match: reset during any state returns to S0 immediately; partial matches are discarded.
- Transition logic may be built via function/generate from PATTERN and PAT_LEN. No hardcoding of the default table except as the result of the rule.

Test Plan:
- Reset: rst=0 with a toggling for 2 cycles -> current=0, q=0 throughout. Release rst -> still current=0 until the first edge.
- Default stream after reset, a per cycle = 0,1,1,0,1,1,1,0 -> current after each edge = 0,1,2,3,4,2,2,3. q=1 only in the cycle with current=4.
- Overlap: stream 1,1,0,1,1,0,1 -> current = 1,2,3,4,2,3,4. q high for two separate single cycles.
- Near misses: streams 1,1,1,1 and 1,0,1,0 -> current never reaches 4; q stays 0. Paths are 1,2,2,2 and 1,0,1,0.
- Async reset mid-operation: drive to S3 (1,1,0), assert rst=0 between edges -> current=0, q=0 immediately without a clock. Resume with 1 -> current=1, not 4.
- Parameter variant: PAT_LEN=3, PATTERN=3'b010, stream 0,1,0,1,0 -> current = 1,2,3,2,3. q high twice.
